// File: rtl/arith_exec_unit.sv
// Clocked arithmetic execution unit: one instruction per valid/ready handshake,
// 32-entry GPR file, SGPR, local data memory, iterative shift-add multiplier.
module arith_exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              err_illegal,
  output logic              busy,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data
);

  localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
  localparam int unsigned NUM_GPR   = 32;
  localparam int unsigned CNT_W     = $clog2(DATA_W);

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_AND     = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_LOAD    = 5'd8;
  localparam logic [4:0] OP_STORE   = 5'd9;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0]         instr_q;
  logic [4:0]          op, rdst, rsrc1, rsrc2;
  logic                imm_mode;
  logic [15:0]         imm;
  logic [DATA_W-1:0]   gpr [NUM_GPR];
  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic [DATA_W-1:0]   op_a, op_b, res, sub_res;
  logic [DATA_W:0]     add_full;
  logic [MEM_AW-1:0]   mem_addr;
  logic                gpr_we, flags_we, mem_we, illegal;
  logic [3:0]          flags_nxt;
  logic [2*DATA_W-1:0] mcand, acc, acc_nxt;
  logic [DATA_W-1:0]   mplr, mul_hi, mul_lo;
  logic [CNT_W-1:0]    bit_cnt;
  logic                mul_last;

  assign op       = instr_q[31:27];
  assign rdst     = instr_q[26:22];
  assign rsrc1    = instr_q[21:17];
  assign imm_mode = instr_q[16];
  assign rsrc2    = instr_q[15:11];
  assign imm      = instr_q[15:0];

  assign op_a     = gpr[rsrc1];
  assign op_b     = imm_mode ? DATA_W'(imm) : gpr[rsrc2];
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_res  = op_a - op_b;
  assign mem_addr = MEM_AW'(op_a + op_b);
  assign illegal  = (op > OP_STORE);

  assign acc_nxt  = mplr[0] ? acc + mcand : acc;
  assign mul_hi   = acc_nxt[2*DATA_W-1:DATA_W];
  assign mul_lo   = acc_nxt[DATA_W-1:0];
  assign mul_last = (state == MUL) && (bit_cnt == CNT_W'(DATA_W - 1));

  assign dbg_rd_data = gpr[dbg_rd_addr];

  // Single-cycle result, flag and write-enable decode for the EXEC state
  always_comb begin
    res       = '0;
    gpr_we    = 1'b0;
    flags_we  = 1'b0;
    mem_we    = 1'b0;
    flags_nxt = flags;
    case (op)
      OP_MOVSGPR: begin res = sgpr; gpr_we = 1'b1; end
      OP_MOV:     begin res = imm_mode ? op_b : op_a; gpr_we = 1'b1; end
      OP_ADD: begin
        res          = add_full[DATA_W-1:0];
        gpr_we       = 1'b1;
        flags_we     = 1'b1;
        flags_nxt[1] = add_full[DATA_W];
        flags_nxt[0] = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        res          = sub_res;
        gpr_we       = 1'b1;
        flags_we     = 1'b1;
        flags_nxt[1] = (op_a < op_b);
        flags_nxt[0] = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND: begin res = op_a & op_b; gpr_we = 1'b1; flags_we = 1'b1; flags_nxt[1:0] = 2'b00; end
      OP_OR:  begin res = op_a | op_b; gpr_we = 1'b1; flags_we = 1'b1; flags_nxt[1:0] = 2'b00; end
      OP_XOR: begin res = op_a ^ op_b; gpr_we = 1'b1; flags_we = 1'b1; flags_nxt[1:0] = 2'b00; end
      OP_LOAD:  begin res = mem[mem_addr]; gpr_we = 1'b1; end
      OP_STORE: mem_we = 1'b1;
      default: ;
    endcase
    if (flags_we) begin
      flags_nxt[3] = res[DATA_W-1];
      flags_nxt[2] = (res == '0);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    state_nxt = (op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_ready <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      err_illegal <= (state == EXEC) && illegal;
    end
  end

  // Architectural state and multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      sgpr    <= '0;
      flags   <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      bit_cnt <= '0;
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == EXEC) begin
        if (gpr_we)   gpr[rdst] <= res;
        if (flags_we) flags     <= flags_nxt;
        if (op == OP_MUL) begin
          mcand   <= {{DATA_W{1'b0}}, op_a};
          mplr    <= op_b;
          acc     <= '0;
          bit_cnt <= '0;
        end
      end
      if (state == MUL) begin
        acc     <= acc_nxt;
        mcand   <= mcand << 1;
        mplr    <= mplr >> 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (mul_last) begin
          gpr[rdst] <= mul_lo;
          sgpr      <= mul_hi;
          flags     <= {mul_lo[DATA_W-1], (mul_lo == '0), (mul_hi != '0), (mul_hi != '0)};
        end
      end
    end
  end

  // Data memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == EXEC && mem_we) mem[mem_addr] <= gpr[rdst];
  end

endmodule

// File: tb/tb_arith_exec_unit.sv
// Scoreboard bench for arith_exec_unit: directed plan plus random instructions
// checked against an arithmetic-level reference model.
module tb_arith_exec_unit;

  localparam int unsigned DW   = 16;
  localparam int unsigned MAW  = 8;
  localparam int          MEMD = 256;
  localparam longint      MOD  = 64'd1 << DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [31:0]   instr = '0;
  logic          done, err_illegal, busy;
  logic [3:0]    flags;
  logic [DW-1:0] sgpr, dbg_rd_data;
  logic [4:0]    dbg_rd_addr = '0;

  arith_exec_unit #(.DATA_W(DW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .err_illegal(err_illegal), .busy(busy), .flags(flags),
    .sgpr(sgpr), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    int            lat;
    logic [DW-1:0] rval;
    logic [3:0]    flg;
    logic [DW-1:0] sg;
    int            acc_cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] m_gpr [32];
  logic [DW-1:0] m_mem [MEMD];
  logic [DW-1:0] m_sgpr;
  logic [3:0]    m_flags;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic longint sval(input longint u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_sgpr  = '0;
    m_flags = '0;
  endtask

  // Reference model: plain integer arithmetic on the architectural state
  task automatic model_exec(input logic [31:0] ins, output exp_t e);
    longint ua, ub, r, t, s;
    logic c, v, upd;
    int addr;
    logic [4:0] op, rd;
    op  = ins[31:27];
    rd  = ins[26:22];
    ua  = m_gpr[ins[21:17]];
    if (ins[16]) ub = ins[15:0];
    else         ub = m_gpr[ins[15:11]];
    addr = int'((ua + ub) % MEMD);
    upd = 1'b0; c = 1'b0; v = 1'b0; r = 0;
    e.err = 1'b0;
    e.lat = 2;
    case (op)
      5'd0: m_gpr[rd] = m_sgpr;
      5'd1: m_gpr[rd] = ins[16] ? DW'(ub) : DW'(ua);
      5'd2: begin
        t = ua + ub; r = t % MOD; c = (t >= MOD);
        s = sval(ua) + sval(ub); v = (s > MOD / 2 - 1) || (s < -(MOD / 2)); upd = 1'b1;
      end
      5'd3: begin
        r = (ua - ub + MOD) % MOD; c = (ua < ub);
        s = sval(ua) - sval(ub); v = (s > MOD / 2 - 1) || (s < -(MOD / 2)); upd = 1'b1;
      end
      5'd4: begin
        t = ua * ub; r = t % MOD; m_sgpr = DW'(t / MOD);
        c = ((t / MOD) != 0); v = c; upd = 1'b1; e.lat = DW + 2;
      end
      5'd5: begin r = ua & ub; upd = 1'b1; end
      5'd6: begin r = ua | ub; upd = 1'b1; end
      5'd7: begin r = ua ^ ub; upd = 1'b1; end
      5'd8: m_gpr[rd] = m_mem[addr];
      5'd9: m_mem[addr] = m_gpr[rd];
      default: e.err = 1'b1;
    endcase
    if (upd) begin
      m_gpr[rd] = DW'(r);
      m_flags   = {(r >= MOD / 2), (r == 0), c, v};
    end
    e.rval    = m_gpr[rd];
    e.flg     = m_flags;
    e.sg      = m_sgpr;
    e.acc_cyc = 0;
  endtask

  // Driver: waits for ready (offering junk while busy), then issues one instruction
  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 400) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr       = $urandom;
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("ready_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    model_exec(ins, e);
    dbg_rd_addr = ins[26:22];
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    e.acc_cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !instr_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic expect_reg(input string name, input logic [4:0] idx, input logic [DW-1:0] val);
    drain();
    dbg_rd_addr = idx;
    #1;
    check(name, 32'(dbg_rd_data), 32'(val));
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", 32'(cyc - mon_e.acc_cyc + 1), 32'(mon_e.lat));
        check("err_illegal", 32'(err_illegal), 32'(mon_e.err));
        check("rd_value", 32'(dbg_rd_data), 32'(mon_e.rval));
        check("flags", 32'(flags), 32'(mon_e.flg));
        check("sgpr", 32'(sgpr), 32'(mon_e.sg));
        check("ready_low_at_done", 32'(instr_ready), 32'd0);
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "time limit");
  end

  initial begin
    int dc;
    model_reset();
    for (int i = 0; i < MEMD; i++) m_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_sgpr", 32'(sgpr), 32'd0);
    check("rst_r0", 32'(dbg_rd_data), 32'd0);

    // Give every memory word a known value (R0 is still zero)
    for (int i = 0; i < MEMD; i++) issue(enc_i(5'd9, 5'd0, 5'd0, 16'(i)));

    issue(enc_i(5'd1, 5'd1, 5'd0, 16'd5));
    issue(enc_i(5'd1, 5'd2, 5'd0, 16'd7));
    issue(enc_r(5'd2, 5'd3, 5'd1, 5'd2));
    expect_reg("plan_add_r3", 5'd3, 16'd12);

    issue(enc_i(5'd1, 5'd1, 5'd0, 16'hFFFF));
    issue(enc_i(5'd2, 5'd5, 5'd1, 16'd1));
    expect_reg("plan_wrap_r5", 5'd5, 16'h0000);
    check("plan_wrap_flags", 32'(flags), 32'b0110);
    issue(enc_i(5'd3, 5'd6, 5'd0, 16'd1));
    expect_reg("plan_sub_r6", 5'd6, 16'hFFFF);
    check("plan_sub_flags", 32'(flags), 32'b1010);
    issue(enc_i(5'd1, 5'd1, 5'd0, 16'h7FFF));
    issue(enc_i(5'd2, 5'd4, 5'd1, 16'h8000));
    expect_reg("plan_add_r4", 5'd4, 16'hFFFF);

    issue(enc_i(5'd1, 5'd1, 5'd0, 16'h1234));
    issue(enc_i(5'd4, 5'd7, 5'd1, 16'h0100));
    expect_reg("plan_mul_r7", 5'd7, 16'h3400);
    check("plan_mul_sgpr", 32'(sgpr), 32'h0012);
    issue(enc_r(5'd0, 5'd8, 5'd0, 5'd0));
    expect_reg("plan_movsgpr_r8", 5'd8, 16'h0012);

    issue(enc_i(5'd1, 5'd9, 5'd0, 16'h00FF));
    issue(enc_i(5'd9, 5'd2, 5'd9, 16'd2));
    issue(enc_i(5'd8, 5'd10, 5'd0, 16'd1));
    expect_reg("plan_load_r10", 5'd10, 16'd7);

    issue(enc_i(5'b11111, 5'd3, 5'd1, 16'hABCD));
    expect_reg("plan_illegal_r3", 5'd3, 16'd12);

    // Reset during the fifth multiply step
    issue(enc_i(5'd4, 5'd7, 5'd1, 16'h0100));
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_flags", 32'(flags), 32'd0);
    check("post_rst_sgpr", 32'(sgpr), 32'd0);
    dbg_rd_addr = 5'd7;
    #1;
    check("post_rst_r7", 32'(dbg_rd_data), 32'd0);
    repeat (25) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt), 32'(dc));

    issue(enc_i(5'd1, 5'd1, 5'd0, 16'h1234));
    issue(enc_i(5'd4, 5'd7, 5'd1, 16'h0100));
    expect_reg("remul_r7", 5'd7, 16'h3400);
    check("remul_sgpr", 32'(sgpr), 32'h0012);
    issue(enc_i(5'd8, 5'd11, 5'd0, 16'd1));
    expect_reg("mem_kept_r11", 5'd11, 16'd7);

    for (int i = 0; i < 120; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      issue({op, 5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom)});
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
